// File: rtl/instruction_fetch_unit_pkg.sv
// rtl/instruction_fetch_unit_pkg.sv - eco32 shared defines: bus size, fetch state encodings, reset vector
package instruction_fetch_unit_pkg;

  localparam logic [1:0]  BUS_SIZE_WORD = 2'b10;

  localparam logic [1:0]  FETCH_STATE_IDLE     = 2'd0;
  localparam logic [1:0]  FETCH_STATE_FETCH    = 2'd1;
  localparam logic [1:0]  FETCH_STATE_PREFETCH = 2'd2;
  localparam logic [1:0]  FETCH_STATE_DISCARD  = 2'd3;

  localparam logic [31:0] RESET_VECTOR_DEFAULT = 32'hE0000000;

  // Sequential successor; wraps modulo 2^32.
  function automatic logic [31:0] next_word_addr(input logic [31:0] a);
    return a + 32'd4;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_prefetch_buffer.sv
// rtl/instruction_fetch_unit_prefetch_buffer.sv - one-entry prefetch buffer (valid, word address, data)
module instruction_prefetch_buffer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fill_i,
  input  logic        inval_i,
  input  logic [29:0] fill_addr_i,
  input  logic [31:0] fill_data_i,
  input  logic [29:0] cmp_addr_i,
  output logic        hit_o,
  output logic [31:0] data_o
);

  logic        valid_q, valid_d;
  logic [29:0] addr_q, addr_d;
  logic [31:0] data_q, data_d;

  always_comb begin
    valid_d = valid_q;
    addr_d  = addr_q;
    data_d  = data_q;
    if (inval_i) valid_d = 1'b0;
    if (fill_i) begin
      valid_d = 1'b1;
      addr_d  = fill_addr_i;
      data_d  = fill_data_i;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
    end
  end

  assign hit_o  = valid_q && (addr_q == cmp_addr_i);
  assign data_o = data_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// rtl/instruction_fetch_unit.sv - ECO32 fetch stage: PC, demand bus reads, fault reporting
// Optional one-entry sequential prefetch when INSTRUCTION_PREFETCH_EN is defined.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_VECTOR = RESET_VECTOR_DEFAULT
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fetchStart,
  input  logic        pcLoad,
  input  logic [31:0] pcLoadValue,
  output logic        busEnable,
  output logic [29:0] busAddress,
  input  logic        busWait,
  input  logic        busError,
  input  logic [31:0] busReadData,
  output logic [31:0] pc,
  output logic [31:0] currentInstruction,
  output logic [31:0] currentInstructionAddress,
  output logic        instructionValid,
  output logic        fetchBusy,
  output logic        fetchFault,
  output logic        fetchFaultMisaligned
);

  logic [1:0]  state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] instr_addr_q, instr_addr_d;
  logic [29:0] bus_addr_q, bus_addr_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  logic        misal_q, misal_d;
  logic [31:0] fetch_pc;
  logic        start_req;

`ifdef INSTRUCTION_PREFETCH_EN
  logic        arm_q, arm_d;
  logic        hold_q, hold_d;
  logic        pf_fill, pf_inval, pf_hit;
  logic [31:0] pf_data;

  instruction_prefetch_buffer u_prefetch_buffer (
    .clk         (clk),
    .reset_n     (reset_n),
    .fill_i      (pf_fill),
    .inval_i     (pf_inval),
    .fill_addr_i (bus_addr_q),
    .fill_data_i (busReadData),
    .cmp_addr_i  (fetch_pc[31:2]),
    .hit_o       (pf_hit),
    .data_o      (pf_data)
  );
`endif

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    instr_d      = instr_q;
    instr_addr_d = instr_addr_q;
    bus_addr_d   = bus_addr_q;
    valid_d      = 1'b0;
    fault_d      = 1'b0;
    misal_d      = 1'b0;
    // A redirect in the same cycle as fetchStart fetches from the new PC.
    fetch_pc     = pcLoad ? pcLoadValue : pc_q;
`ifdef INSTRUCTION_PREFETCH_EN
    arm_d        = pcLoad ? 1'b0 : arm_q;
    hold_d       = hold_q;
    pf_fill      = 1'b0;
    pf_inval     = pcLoad;
    start_req    = fetchStart | hold_q;
`else
    start_req    = fetchStart;
`endif
    if (pcLoad) pc_d = pcLoadValue;

    case (state_q)
      FETCH_STATE_IDLE: begin
        if (start_req) begin
          if (fetch_pc[1:0] != 2'b00) begin
            fault_d = 1'b1;
            misal_d = 1'b1;
          end
`ifdef INSTRUCTION_PREFETCH_EN
          else if (pf_hit && !pcLoad) begin
            instr_d      = pf_data;
            instr_addr_d = fetch_pc;
            pc_d         = next_word_addr(fetch_pc);
            valid_d      = 1'b1;
            state_d      = FETCH_STATE_PREFETCH;
            bus_addr_d   = next_word_addr(fetch_pc) >> 2;
            arm_d        = 1'b0;
          end
`endif
          else begin
            state_d    = FETCH_STATE_FETCH;
            bus_addr_d = fetch_pc[31:2];
          end
`ifdef INSTRUCTION_PREFETCH_EN
          hold_d = 1'b0;
        end else if (arm_q && !pcLoad) begin
          state_d    = FETCH_STATE_PREFETCH;
          bus_addr_d = pc_q[31:2];
          arm_d      = 1'b0;
`endif
        end
      end
      FETCH_STATE_FETCH: begin
        if (!busWait) begin
          state_d = FETCH_STATE_IDLE;
          if (busError) begin
            fault_d = 1'b1;
          end else begin
            instr_d      = busReadData;
            instr_addr_d = {bus_addr_q, 2'b00};
            pc_d         = next_word_addr({bus_addr_q, 2'b00});
            valid_d      = 1'b1;
`ifdef INSTRUCTION_PREFETCH_EN
            arm_d        = 1'b1;
`endif
          end
        end
      end
`ifdef INSTRUCTION_PREFETCH_EN
      FETCH_STATE_PREFETCH: begin
        if (pcLoad) begin
          hold_d  = fetchStart;
          state_d = busWait ? FETCH_STATE_DISCARD : FETCH_STATE_IDLE;
        end else if (fetchStart) begin
          // The speculative read is for pc, so promote it to the demand read.
          if (busWait) begin
            state_d = FETCH_STATE_FETCH;
          end else begin
            state_d = FETCH_STATE_IDLE;
            if (busError) begin
              fault_d = 1'b1;
            end else begin
              instr_d      = busReadData;
              instr_addr_d = {bus_addr_q, 2'b00};
              pc_d         = next_word_addr({bus_addr_q, 2'b00});
              valid_d      = 1'b1;
              arm_d        = 1'b1;
            end
          end
        end else if (!busWait) begin
          state_d = FETCH_STATE_IDLE;
          pf_fill = !busError;
        end
      end
      FETCH_STATE_DISCARD: begin
        hold_d = hold_q | fetchStart;
        if (!busWait) state_d = FETCH_STATE_IDLE;
      end
`endif
      default: state_d = FETCH_STATE_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= FETCH_STATE_IDLE;
      pc_q         <= RESET_VECTOR;
      instr_q      <= '0;
      instr_addr_q <= '0;
      bus_addr_q   <= '0;
      valid_q      <= 1'b0;
      fault_q      <= 1'b0;
      misal_q      <= 1'b0;
`ifdef INSTRUCTION_PREFETCH_EN
      arm_q        <= 1'b0;
      hold_q       <= 1'b0;
`endif
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      instr_q      <= instr_d;
      instr_addr_q <= instr_addr_d;
      bus_addr_q   <= bus_addr_d;
      valid_q      <= valid_d;
      fault_q      <= fault_d;
      misal_q      <= misal_d;
`ifdef INSTRUCTION_PREFETCH_EN
      arm_q        <= arm_d;
      hold_q       <= hold_d;
`endif
    end
  end

`ifdef INSTRUCTION_PREFETCH_EN
  assign busEnable = (state_q != FETCH_STATE_IDLE);
`else
  assign busEnable = (state_q == FETCH_STATE_FETCH);
`endif
  assign fetchBusy                 = (state_q == FETCH_STATE_FETCH) || (state_q == FETCH_STATE_DISCARD);
  assign busAddress                = bus_addr_q;
  assign pc                        = pc_q;
  assign currentInstruction        = instr_q;
  assign currentInstructionAddress = instr_addr_q;
  assign instructionValid          = valid_q;
  assign fetchFault                = fault_q;
  assign fetchFaultMisaligned      = misal_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// tb/tb_instruction_fetch_unit.sv - randomized self-checking bench for instruction_fetch_unit (default build)
module tb_instruction_fetch_unit;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        fetchStart = 1'b0;
  logic        pcLoad = 1'b0;
  logic [31:0] pcLoadValue = '0;
  logic        busWait = 1'b0;
  logic        busError = 1'b0;
  logic [31:0] busReadData = '0;
  logic        busEnable;
  logic [29:0] busAddress;
  logic [31:0] pc;
  logic [31:0] currentInstruction;
  logic [31:0] currentInstructionAddress;
  logic        instructionValid;
  logic        fetchBusy;
  logic        fetchFault;
  logic        fetchFaultMisaligned;

  int vectors = 0;
  int miscompares = 0;

  logic [31:0] pc_m, instr_m, iaddr_m;

  instruction_fetch_unit dut (
    .clk                       (clk),
    .reset_n                   (reset_n),
    .fetchStart                (fetchStart),
    .pcLoad                    (pcLoad),
    .pcLoadValue               (pcLoadValue),
    .busEnable                 (busEnable),
    .busAddress                (busAddress),
    .busWait                   (busWait),
    .busError                  (busError),
    .busReadData               (busReadData),
    .pc                        (pc),
    .currentInstruction        (currentInstruction),
    .currentInstructionAddress (currentInstructionAddress),
    .instructionValid          (instructionValid),
    .fetchBusy                 (fetchBusy),
    .fetchFault                (fetchFault),
    .fetchFaultMisaligned      (fetchFaultMisaligned)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'hE0000000) return 32'h2C220005;
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic load_only(input logic [31:0] v);
    @(negedge clk);
    pcLoad = 1'b1;
    pcLoadValue = v;
    pc_m = v;
    @(negedge clk);
    pcLoad = 1'b0;
    check("load_pc", pc, pc_m);
    check("load_busen", {31'd0, busEnable}, 32'd0);
  endtask

  // One demand fetch from the model's point of view: fetchStart in cycle N,
  // optional same-cycle redirect, 'waits' wait states, optional bus error.
  task automatic fetch_txn(input bit with_load, input logic [31:0] lv, input int waits, input bit err);
    logic [31:0] word;
    @(negedge clk);
    fetchStart = 1'b1;
    pcLoad = with_load;
    pcLoadValue = lv;
    if (with_load) pc_m = lv;
    @(negedge clk);
    fetchStart = 1'b0;
    pcLoad = 1'b0;
    if (pc_m[1:0] != 2'b00) begin
      check("mis_busen", {31'd0, busEnable}, 32'd0);
      check("mis_fault", {31'd0, fetchFault}, 32'd1);
      check("mis_cause", {31'd0, fetchFaultMisaligned}, 32'd1);
      check("mis_valid", {31'd0, instructionValid}, 32'd0);
      check("mis_pc", pc, pc_m);
      @(negedge clk);
      check("mis_fault_pulse", {31'd0, fetchFault}, 32'd0);
      check("mis_busen2", {31'd0, busEnable}, 32'd0);
      return;
    end
    word = mem_word(pc_m);
    for (int k = 0; k <= waits; k++) begin
      check("busen", {31'd0, busEnable}, 32'd1);
      check("busaddr", {2'b00, busAddress}, {2'b00, pc_m[31:2]});
      check("busy", {31'd0, fetchBusy}, 32'd1);
      check("valid_early", {31'd0, instructionValid}, 32'd0);
      check("fault_early", {31'd0, fetchFault}, 32'd0);
      busWait = (k < waits);
      busError = (k == waits) && err;
      busReadData = (k == waits) ? word : $urandom;
      fetchStart = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    fetchStart = 1'b0;
    busWait = 1'b0;
    busError = 1'b0;
    check("done_busen", {31'd0, busEnable}, 32'd0);
    check("done_busy", {31'd0, fetchBusy}, 32'd0);
    check("done_valid", {31'd0, instructionValid}, {31'd0, !err});
    check("done_fault", {31'd0, fetchFault}, {31'd0, err});
    check("done_cause", {31'd0, fetchFaultMisaligned}, 32'd0);
    if (!err) begin
      instr_m = word;
      iaddr_m = pc_m;
      pc_m = pc_m + 32'd4;
    end
    check("done_pc", pc, pc_m);
    check("done_instr", currentInstruction, instr_m);
    check("done_iaddr", currentInstructionAddress, iaddr_m);
  endtask

  initial begin
    int kind, w;
    bit e;
    logic [31:0] a;

    #12;
    check("rst_pc", pc, 32'hE0000000);
    check("rst_instr", currentInstruction, 32'd0);
    check("rst_iaddr", currentInstructionAddress, 32'd0);
    check("rst_busen", {31'd0, busEnable}, 32'd0);
    check("rst_valid", {31'd0, instructionValid}, 32'd0);
    check("rst_busy", {31'd0, fetchBusy}, 32'd0);
    check("rst_fault", {31'd0, fetchFault}, 32'd0);
    check("rst_cause", {31'd0, fetchFaultMisaligned}, 32'd0);
    @(negedge clk);
    reset_n = 1'b1;
    pc_m = 32'hE0000000;
    instr_m = '0;
    iaddr_m = '0;

    fetch_txn(1'b0, 32'h0, 0, 1'b0);
    fetch_txn(1'b1, 32'hE0000000, 3, 1'b0);
    fetch_txn(1'b1, 32'h00001002, 0, 1'b0);
    fetch_txn(1'b1, 32'h00001000, 1, 1'b1);
    fetch_txn(1'b0, 32'h0, 0, 1'b0);
    fetch_txn(1'b1, 32'hFFFFFFFC, 0, 1'b0);
    fetch_txn(1'b0, 32'h0, 2, 1'b0);
    load_only(32'h00000FF8);
    fetch_txn(1'b0, 32'h0, 0, 1'b0);

    for (int i = 0; i < 30; i++) begin
      kind = $urandom_range(0, 9);
      a = $urandom;
      a[1:0] = (kind == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
      w = $urandom_range(0, 3);
      e = ($urandom_range(0, 4) == 0);
      if (kind < 3) fetch_txn(1'b1, a, w, e);
      else if (kind == 3) load_only(a);
      else fetch_txn(1'b0, 32'h0, w, e);
    end

    @(negedge clk);
    fetchStart = 1'b1;
    busWait = 1'b1;
    @(negedge clk);
    fetchStart = 1'b0;
    check("midrst_busen_before", {31'd0, busEnable}, 32'd1);
    #2 reset_n = 1'b0;
    #1;
    check("midrst_busen", {31'd0, busEnable}, 32'd0);
    check("midrst_busy", {31'd0, fetchBusy}, 32'd0);
    check("midrst_pc", pc, 32'hE0000000);
    check("midrst_instr", currentInstruction, 32'd0);
    check("midrst_iaddr", currentInstructionAddress, 32'd0);
    check("midrst_valid", {31'd0, instructionValid}, 32'd0);
    check("midrst_fault", {31'd0, fetchFault}, 32'd0);
    @(negedge clk);
    busWait = 1'b0;
    reset_n = 1'b1;
    pc_m = 32'hE0000000;
    instr_m = '0;
    iaddr_m = '0;
    @(negedge clk);
    check("postrst_pc", pc, pc_m);
    check("postrst_busen", {31'd0, busEnable}, 32'd0);
    fetch_txn(1'b0, 32'h0, 0, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
